// File: rtl/bus_rr_dispatcher.sv
// rtl/bus_rr_dispatcher.sv - round-robin source-to-destination packet dispatcher for the shared bus
module bus_rr_dispatcher #(
  parameter int         drvrs     = 4,
  parameter int         pckg_sz   = 16,
  parameter logic [7:0] broadcast = 8'hFF,
  parameter int         max_wait  = 15
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [drvrs-1:0]           pndng,
  input  logic [drvrs*pckg_sz-1:0]   D_pop,
  output logic [drvrs-1:0]           pop,
  input  logic [drvrs-1:0]           full,
  output logic [drvrs-1:0]           push,
  output logic [pckg_sz-1:0]         D_push,
  output logic [3:0]                 gnt_id,
  output logic                       busy,
  output logic                       err_drop
);

  localparam int IW = (drvrs > 1) ? $clog2(drvrs) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ROUTE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_HOLD  = 2'd3;

  localparam logic [drvrs-1:0] one_hot0 = {{(drvrs-1){1'b0}}, 1'b1};

  logic [1:0]          state;
  logic [IW-1:0]       ptr;
  logic [IW-1:0]       gnt_q;
  logic [pckg_sz-1:0]  pkt;
  logic [7:0]          cnt;

  logic                hi_found;
  logic [IW-1:0]       hi_id;
  logic                lo_found;
  logic [IW-1:0]       lo_id;
  logic                win_found;
  logic [IW-1:0]       win_id;
  logic [pckg_sz-1:0]  win_data;

  logic [7:0]          dest;
  logic                mask_ok;
  logic [drvrs-1:0]    mask;
  logic                mask_clear;

  assign gnt_id = 4'(gnt_q);

  // Rotating priority: first pending source at or above ptr, else the first pending below it
  always_comb begin
    hi_found = 1'b0;
    hi_id    = '0;
    lo_found = 1'b0;
    lo_id    = '0;
    for (int i = drvrs - 1; i >= 0; i--) begin
      if (pndng[i]) begin
        lo_found = 1'b1;
        lo_id    = IW'(i);
        if (IW'(i) >= ptr) begin
          hi_found = 1'b1;
          hi_id    = IW'(i);
        end
      end
    end
    win_found = hi_found | lo_found;
    win_id    = hi_found ? hi_id : lo_id;
  end

  // Head-of-FIFO data of the winning source
  always_comb begin
    win_data = '0;
    for (int i = 0; i < drvrs; i++) begin
      if (win_id == IW'(i)) begin
        win_data = D_pop[i*pckg_sz +: pckg_sz];
      end
    end
  end

  // Destination mask from the latched packet; an empty mask means the packet is undeliverable
  always_comb begin
    dest    = pkt[pckg_sz-1 -: 8];
    mask    = '0;
    mask_ok = 1'b0;
    if (dest == broadcast) begin
      mask    = ~(one_hot0 << gnt_q);
      mask_ok = 1'b1;
    end else if ((dest < 8'(drvrs)) && (dest != 8'(gnt_q))) begin
      mask    = one_hot0 << dest;
      mask_ok = 1'b1;
    end
    mask_clear = ((mask & full) == '0);
  end

  // Grant / route / wait / hold sequencer; strobes default low so they pulse for one cycle
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= S_IDLE;
      ptr      <= '0;
      gnt_q    <= '0;
      pkt      <= '0;
      cnt      <= '0;
      pop      <= '0;
      push     <= '0;
      D_push   <= '0;
      busy     <= 1'b0;
      err_drop <= 1'b0;
    end else begin
      pop      <= '0;
      push     <= '0;
      err_drop <= 1'b0;
      case (state)
        S_IDLE: begin
          if (win_found) begin
            gnt_q <= win_id;
            pkt   <= win_data;
            pop   <= one_hot0 << win_id;
            busy  <= 1'b1;
            state <= S_ROUTE;
          end
        end
        S_ROUTE: begin
          if (!mask_ok) begin
            err_drop <= 1'b1;
            state    <= S_HOLD;
          end else if (mask_clear) begin
            push   <= mask;
            D_push <= pkt;
            state  <= S_HOLD;
          end else begin
            cnt   <= '0;
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (mask_clear) begin
            push   <= mask;
            D_push <= pkt;
            state  <= S_HOLD;
          end else if (cnt == 8'(max_wait)) begin
            err_drop <= 1'b1;
            state    <= S_HOLD;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_HOLD: begin
          ptr   <= (gnt_q == IW'(drvrs - 1)) ? '0 : gnt_q + IW'(1);
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_rr_dispatcher.sv
// tb/tb_bus_rr_dispatcher.sv - self-checking bench for bus_rr_dispatcher
module tb_bus_rr_dispatcher;

  localparam int NDRV = 4;
  localparam int PW   = 16;
  localparam int MAXW = 15;

  logic                 clk_tb = 1'b0;
  logic                 reset;
  logic [NDRV-1:0]      pndng;
  logic [NDRV*PW-1:0]   D_pop;
  logic [NDRV-1:0]      pop;
  logic [NDRV-1:0]      full;
  logic [NDRV-1:0]      push;
  logic [PW-1:0]        D_push;
  logic [3:0]           gnt_id;
  logic                 busy;
  logic                 err_drop;

  int n_checked  = 0;
  int n_mismatch = 0;
  int cyc        = 0;
  int ptr_m      = 0;

  logic [PW-1:0] srcq [NDRV][$];

  int            obs_push_k;
  int            obs_err_k;
  int            obs_pop_cyc;
  logic [NDRV-1:0] obs_push;
  logic [PW-1:0] obs_dpush;
  logic [3:0]    obs_gnt;

  int rr_gnt [4];
  int rr_cyc [4];

  bus_rr_dispatcher #(
    .drvrs    (NDRV),
    .pckg_sz  (PW),
    .broadcast(8'hFF),
    .max_wait (MAXW)
  ) dut (
    .clk     (clk_tb),
    .reset   (reset),
    .pndng   (pndng),
    .D_pop   (D_pop),
    .pop     (pop),
    .full    (full),
    .push    (push),
    .D_push  (D_push),
    .gnt_id  (gnt_id),
    .busy    (busy),
    .err_drop(err_drop)
  );

  always #5 clk_tb = ~clk_tb;

  always @(posedge clk_tb) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checked++;
    if (got !== exp) begin
      n_mismatch++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_tb);
    #1;
  endtask

  task automatic drive_src();
    for (int i = 0; i < NDRV; i++) begin
      pndng[i] = (srcq[i].size() != 0);
      D_pop[i*PW +: PW] = pndng[i] ? srcq[i][0] : PW'($urandom);
    end
  endtask

  function automatic int pick(input int p);
    for (int off = 0; off < NDRV; off++) begin
      if (srcq[(p + off) % NDRV].size() != 0) return (p + off) % NDRV;
    end
    return -1;
  endfunction

  function automatic logic [NDRV-1:0] exp_mask(input int src, input logic [PW-1:0] pk);
    int dest;
    dest = int'(pk[PW-1 -: 8]);
    if (dest == 255) return {NDRV{1'b1}} & ~(NDRV'(1) << src);
    if (dest < NDRV && dest != src) return NDRV'(1) << dest;
    return '0;
  endfunction

  function automatic logic [PW-1:0] rand_pkt();
    logic [7:0] d;
    case ($urandom_range(0, 5))
      0:       d = 8'hFF;
      1:       d = 8'($urandom_range(4, 254));
      default: d = 8'($urandom_range(0, NDRV - 1));
    endcase
    return {d, 8'($urandom)};
  endfunction

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_pop"}, pop, 0);
    check_eq({tag, "_push"}, push, 0);
    check_eq({tag, "_dpush"}, D_push, 0);
    check_eq({tag, "_gnt"}, gnt_id, 0);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_drop"}, err_drop, 0);
  endtask

  task automatic apply_reset();
    for (int i = 0; i < NDRV; i++) srcq[i].delete();
    reset = 1'b0;
    pndng = '0;
    full  = '0;
    step();
    step();
    check_all_zero("rst");
    reset = 1'b1;
    ptr_m = 0;
  endtask

  // One grant opportunity: blocks the chosen masked destination for blk_len checks,
  // optionally asserting reset before check number abort_k.
  task automatic run_packet(input int blk_len, input logic [NDRV-1:0] blk_req, input int abort_k);
    int w;
    int k;
    int i;
    bit done;
    logic [PW-1:0]   pk;
    logic [NDRV-1:0] mask;
    logic [NDRV-1:0] blk;
    obs_push_k = -1;
    obs_err_k  = -1;
    obs_push   = '0;
    obs_dpush  = '0;
    drive_src();
    full = NDRV'($urandom);
    w = pick(ptr_m);
    if (w < 0) begin
      step();
      check_eq("idle_busy", busy, 0);
      check_eq("idle_pop", pop, 0);
      check_eq("idle_push", push, 0);
      return;
    end
    pk = srcq[w].pop_front();
    step();
    obs_pop_cyc = cyc;
    obs_gnt     = gnt_id;
    check_eq("pop", pop, NDRV'(1) << w);
    check_eq("gnt_id", gnt_id, w);
    check_eq("busy_pop", busy, 1);
    check_eq("push_at_pop", push, 0);
    drive_src();
    mask = exp_mask(w, pk);
    if (mask == '0) begin
      full = NDRV'($urandom);
      step();
      if (err_drop) obs_err_k = 0;
      obs_push = push;
      check_eq("drop_invalid", err_drop, 1);
      check_eq("push_invalid", push, 0);
      check_eq("pop_route", pop, 0);
    end else begin
      blk = blk_req & mask;
      if (blk == '0) begin
        do i = $urandom_range(0, NDRV - 1); while (!mask[i]);
        blk = NDRV'(1) << i;
      end
      done = 1'b0;
      for (k = 0; k <= MAXW + 1 && !done; k++) begin
        if (k == abort_k) begin
          reset = 1'b0;
          step();
          check_all_zero("abort");
          reset = 1'b1;
          ptr_m = 0;
          return;
        end
        full = (NDRV'($urandom) & ~mask) | ((k < blk_len) ? blk : '0);
        step();
        if (push != '0 && obs_push_k < 0) begin
          obs_push_k = k;
          obs_push   = push;
          obs_dpush  = D_push;
        end
        if (err_drop && obs_err_k < 0) obs_err_k = k;
        check_eq("pop_route", pop, 0);
        if ((full & mask) == '0) begin
          check_eq("push_mask", push, mask);
          check_eq("push_data", D_push, pk);
          check_eq("no_drop", err_drop, 0);
          done = 1'b1;
        end else if (k == MAXW + 1) begin
          check_eq("timeout_drop", err_drop, 1);
          check_eq("timeout_push", push, 0);
        end else begin
          check_eq("wait_push", push, 0);
          check_eq("wait_drop", err_drop, 0);
          check_eq("wait_busy", busy, 1);
        end
      end
    end
    full = NDRV'($urandom);
    step();
    check_eq("hold_busy", busy, 0);
    check_eq("hold_push", push, 0);
    check_eq("hold_drop", err_drop, 0);
    check_eq("hold_gnt", gnt_id, w);
    ptr_m = (w + 1) % NDRV;
  endtask

  initial begin
    reset = 1'b0;
    pndng = '0;
    full  = '0;
    D_pop = '0;

    apply_reset();

    srcq[0].push_back(16'h02AB);
    run_packet(0, '0, -1);
    check_eq("single_push", obs_push, 4'b0100);
    check_eq("single_data", obs_dpush, 16'h02AB);
    check_eq("single_k", obs_push_k, 0);

    apply_reset();
    for (int s = 0; s < NDRV; s++) begin
      for (int j = 0; j < 2; j++) srcq[s].push_back({8'((s + 1) % NDRV), 8'($urandom)});
    end
    for (int n = 0; n < 4; n++) begin
      run_packet(0, '0, -1);
      rr_gnt[n] = int'(obs_gnt);
      rr_cyc[n] = obs_pop_cyc;
    end
    for (int n = 0; n < 4; n++) check_eq($sformatf("rr_gnt%0d", n), rr_gnt[n], n);
    for (int n = 1; n < 4; n++) check_eq($sformatf("rr_gap%0d", n), rr_cyc[n] - rr_cyc[n-1], 3);
    for (int s = 0; s < NDRV; s++) srcq[s].delete();

    srcq[2].push_back(16'hFF55);
    run_packet(0, '0, -1);
    check_eq("bcast_push", obs_push, 4'b1011);
    check_eq("bcast_data", obs_dpush, 16'hFF55);

    srcq[0].push_back(16'h03C4);
    run_packet(5, 4'b1000, -1);
    check_eq("bp_k", obs_push_k, 5);
    check_eq("bp_push", obs_push, 4'b1000);
    check_eq("bp_drop", obs_err_k, -1);

    srcq[0].push_back(16'h0177);
    run_packet(40, 4'b0010, -1);
    check_eq("to_drop_k", obs_err_k, MAXW + 1);
    check_eq("to_push_k", obs_push_k, -1);

    srcq[1].push_back(16'h0712);
    run_packet(0, '0, -1);
    check_eq("inv_drop_k", obs_err_k, 0);
    check_eq("inv_push", obs_push, 0);

    srcq[3].push_back(16'h0399);
    run_packet(0, '0, -1);
    check_eq("self_drop_k", obs_err_k, 0);
    check_eq("self_push", obs_push, 0);

    srcq[2].push_back(16'h0011);
    run_packet(40, 4'b0001, 5);
    srcq[1].push_back(16'h0222);
    srcq[3].push_back(16'h0033);
    run_packet(0, '0, -1);
    check_eq("post_rst_gnt", obs_gnt, 1);
    for (int s = 0; s < NDRV; s++) srcq[s].delete();

    apply_reset();
    for (int n = 0; n < 300; n++) begin
      int blen;
      int abort_k;
      if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(1, 2)) srcq[$urandom_range(0, NDRV - 1)].push_back(rand_pkt());
      end
      blen    = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 20)) : 0;
      abort_k = ($urandom_range(0, 39) == 0) ? int'($urandom_range(0, 10)) : -1;
      run_packet(blen, '0, abort_k);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checked, n_mismatch);
    $finish;
  end

endmodule
